mmio_timer: RTL

- Memory-mapped countdown timer that acts as the bus responder to the CPU's load/store port (address, write data, write enable) and raises an interrupt request toward the CPU's CP0.
- It provides CTRL, PRESET and COUNT registers and a 4-state counting FSM.
- It sits beside DM behind the CPU's data-address decode and drives one hardware interrupt line.

---
 rtl/mmio_timer_if.sv | 10 +
 rtl/mmio_timer.sv | 83 ++++++++
 2 files changed

// File: rtl/mmio_timer_if.sv
// mmio_timer_if: CPU load/store port toward the timer plus its interrupt line
interface mmio_timer_if;
   logic [31:0] addr;
   logic [31:0] wd;
   logic [31:0] rd;
   logic        we;
   logic        irq;
   modport master (output addr, we, wd, input rd, irq);
   modport slave (input addr, we, wd, output rd, irq);
endinterface

// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped countdown timer (CTRL/PRESET/COUNT) raising irq; MMIO_TIMER_PRESCALE_EN adds a CTRL[7:4] prescaler
module mmio_timer #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
   input logic clk,
   input logic reset,
   mmio_timer_if.slave bus
);
`ifdef MMIO_TIMER_PRESCALE_EN
   localparam int CW = 8;
`else
   localparam int CW = 4;
`endif
   typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;
   state_t state;
   logic [CW-1:0] ctrl;
   logic [31:0] preset, count;
   logic irq_flag, hit, wr_ctrl, wr_preset, tick, unused;
   assign hit = bus.addr[31:4] == BASE_ADDR[31:4];
   assign wr_ctrl = bus.we && hit && bus.addr[3:2] == 2'd0;
   assign wr_preset = bus.we && hit && bus.addr[3:2] == 2'd1;
   assign unused = ^bus.addr[1:0];
`ifdef MMIO_TIMER_PRESCALE_EN
   logic [3:0] psc_cnt;
   assign tick = psc_cnt == ctrl[7:4];
   // prescale counter restarts on every load and every decrement
   always_ff @(posedge clk) begin
      if (reset) psc_cnt <= '0;
      else if (state == LOAD || (state == CNT && tick)) psc_cnt <= '0;
      else if (state == CNT) psc_cnt <= psc_cnt + 4'd1;
   end
`else
   assign tick = 1'b1;
`endif
   // read data is a pure function of the address and the current registers
   always_comb begin
      bus.rd = !hit ? 32'd0 :
               bus.addr[3:2] == 2'd0 ? {{(32-CW){1'b0}}, ctrl} :
               bus.addr[3:2] == 2'd1 ? preset :
               bus.addr[3:2] == 2'd2 ? count : 32'd0;
   end
   assign bus.irq = irq_flag & ctrl[3];
   // counting FSM and registers; the CPU CTRL write comes last so it overrides the INT-state EN clear
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         ctrl     <= '0;
         preset   <= '0;
         count    <= '0;
         irq_flag <= 1'b0;
      end else begin
         case (state)
            IDLE: if (ctrl[0]) state <= LOAD;
            LOAD: begin
               count <= preset;
               state <= CNT;
            end
            CNT: begin
               if (!ctrl[0]) state <= IDLE;
               else if (tick) begin
                  if (count > 32'd1) count <= count - 32'd1;
                  else begin
                     count    <= '0;
                     irq_flag <= 1'b1;
                     state    <= INT;
                  end
               end
            end
            INT: begin
               state <= IDLE;
               if (ctrl[2:1] == 2'd0) ctrl[0] <= 1'b0;
               else irq_flag <= 1'b0;
            end
            default: state <= IDLE;
         endcase
         if (wr_preset) preset <= bus.wd;
         if (wr_ctrl) begin
            ctrl     <= bus.wd[CW-1:0];
            irq_flag <= 1'b0;
         end
      end
   end
endmodule
